// File: rtl/instr_cache_l1_assoc.sv
// instr_cache_l1_assoc: set-associative L1 instruction cache with round-robin replacement and flush sweep
// Ports: CLK/RESET (sync, active-low); instr_addressIF/fetch_valid fetch lookup; flush starts an invalidate sweep;
// instr_out/hit fetched word; flush_busy high during the sweep; mem_req/mem_address/mem_data/mem_valid line fill port.
module instr_cache_l1_assoc #(
  parameter int SETS = 256,
  parameter int WAYS = 2,
  parameter int LINE_WORDS = 8,
  localparam int LINE_W = 32 * LINE_WORDS
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       instr_addressIF,
  input  logic              fetch_valid,
  input  logic              flush,
  output logic [31:0]       instr_out,
  output logic              hit,
  output logic              flush_busy,
  input  logic [LINE_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              mem_req,
  output logic [31:0]       mem_address
);
  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int OFF_W = WRD_W + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W;
  localparam int RR_W = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic [1:0] {IDLE, MISS, FLUSH} state_t;
  state_t state_q, state_n;
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [RR_W-1:0]   rr_q    [SETS];
  logic [IDX_W-1:0]  set_ctr;
  logic [31-OFF_W:0] miss_line;
  logic              flush_pend;
  logic [IDX_W-1:0]  idx, m_idx;
  logic [TAG_W-1:0]  a_tag, m_tag;
  logic [WRD_W-1:0]  word;
  logic [WAYS-1:0]   match;
  logic [LINE_W-1:0] line;
  logic [RR_W-1:0]   victim;
  logic              miss_start, fill;
  assign idx = instr_addressIF[OFF_W+IDX_W-1:OFF_W];
  assign a_tag = instr_addressIF[31:OFF_W+IDX_W];
  assign word = instr_addressIF[OFF_W-1:2];
  assign m_idx = miss_line[IDX_W-1:0];
  assign m_tag = miss_line[31-OFF_W:IDX_W];
  // Tags within a set are unique, so OR-ing the matching lines is a one-hot mux.
  always_comb begin
    match = '0;
    line = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[idx][w] && tag_q[idx][w] == a_tag) begin
        match[w] = 1'b1;
        line = line | data_q[idx][w];
      end
  end
  assign hit = fetch_valid && state_q == IDLE && |match;
  assign instr_out = hit ? line[LINE_W-1-32*int'(word) -: 32] : 32'd0;
  assign flush_busy = state_q == FLUSH;
  // Lowest invalid way wins; the round-robin pointer only applies to a full set.
  always_comb begin
    victim = rr_q[m_idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[m_idx][w]) victim = RR_W'(w);
  end
  assign miss_start = state_q == IDLE && !flush && fetch_valid && !hit;
  assign fill = state_q == MISS && mem_valid;
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    state_n = flush ? FLUSH : miss_start ? MISS : IDLE;
      MISS:    state_n = mem_valid ? ((flush_pend || flush) ? FLUSH : IDLE) : MISS;
      default: state_n = set_ctr == IDX_W'(SETS - 1) ? IDLE : FLUSH;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= FLUSH;
      set_ctr <= '0;
      mem_req <= 1'b0;
      mem_address <= '0;
      flush_pend <= 1'b0;
    end else begin
      state_q <= state_n;
      set_ctr <= state_q == FLUSH ? set_ctr + 1'b1 : '0;
      flush_pend <= state_q == MISS && !mem_valid && (flush_pend || flush);
      if (miss_start) begin
        mem_req <= 1'b1;
        mem_address <= {instr_addressIF[31:OFF_W], {OFF_W{1'b0}}};
        miss_line <= instr_addressIF[31:OFF_W];
      end
      if (fill) begin
        mem_req <= 1'b0;
        mem_address <= '0;
      end
    end
  end
  // Arrays carry no reset; valid bits are cleared by the sweep that reset starts.
  always_ff @(posedge CLK) begin
    if (RESET && fill) begin
      valid_q[m_idx][victim] <= 1'b1;
      tag_q[m_idx][victim] <= m_tag;
      data_q[m_idx][victim] <= mem_data;
      rr_q[m_idx] <= RR_W'((int'(victim) + 1) % WAYS);
    end
    if (RESET && state_q == FLUSH) begin
      valid_q[set_ctr] <= '0;
      rr_q[set_ctr] <= '0;
    end
  end
endmodule
